// File: rtl/dispatch_pipe_reg.sv
// rtl/dispatch_pipe_reg.sv - decode-to-execute pipeline register with per-unit dispatch handshakes
module dispatch_pipe_reg #(
   parameter int DATA_W    = 160,
   parameter int NUM_UNITS = 3,
   parameter int SKID      = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 flush,
   input  logic                 valid_in,
   output logic                 ready_out,
   input  logic [DATA_W-1:0]    data_in,
   input  logic [NUM_UNITS-1:0] unit_sel_in,
   output logic                 valid_out,
   input  logic                 ready_in,
   output logic [DATA_W-1:0]    data_out,
   output logic [NUM_UNITS-1:0] valid_out_unit,
   input  logic [NUM_UNITS-1:0] ready_in_unit,
   output logic [1:0]           occupancy
);

   localparam bit HAS_SKID = (SKID != 0);

   // head entry: payload, pending unit mask, main-path-done flag
   logic                 h_valid_q, h_valid_d;
   logic [DATA_W-1:0]    h_data_q, h_data_d;
   logic [NUM_UNITS-1:0] p_q, p_d;
   logic                 m_q, m_d;
   // skid entry: only ever occupied when SKID is enabled
   logic                 s_valid_q, s_valid_d;
   logic [DATA_W-1:0]    s_data_q, s_data_d;
   logic [NUM_UNITS-1:0] s_sel_q, s_sel_d;

   logic                 main_acc;
   logic [NUM_UNITS-1:0] unit_acc;
   logic                 retire;
   logic                 head_free;
   logic                 load;

   // handshake decode; flush masks every offer so nothing is consumed while killing
   always_comb begin
      valid_out      = h_valid_q & ~m_q & ~flush;
      valid_out_unit = p_q & {NUM_UNITS{h_valid_q & ~flush}};
      main_acc       = valid_out & ready_in;
      unit_acc       = valid_out_unit & ready_in_unit;
      retire         = h_valid_q & ~flush & (m_q | main_acc) & ((p_q & ~unit_acc) == '0);
      head_free      = ~h_valid_q | retire;
      // with a skid slot, ready depends only on state so it can be timed from a flop
      ready_out      = HAS_SKID ? ~s_valid_q : head_free;
      load           = valid_in & ready_out & ~flush;
      data_out       = h_data_q;
      occupancy      = {1'b0, h_valid_q} + {1'b0, s_valid_q};
   end

   // next-state: flush wins, then head refill from skid (older) before fresh input
   always_comb begin
      h_valid_d = h_valid_q;
      h_data_d  = h_data_q;
      p_d       = p_q & ~unit_acc;
      m_d       = m_q | main_acc;
      s_valid_d = s_valid_q;
      s_data_d  = s_data_q;
      s_sel_d   = s_sel_q;
      if (flush) begin
         h_valid_d = 1'b0;
         h_data_d  = '0;
         p_d       = '0;
         m_d       = 1'b0;
         s_valid_d = 1'b0;
         s_data_d  = '0;
         s_sel_d   = '0;
      end else if (head_free) begin
         if (HAS_SKID && s_valid_q) begin
            h_valid_d = 1'b1;
            h_data_d  = s_data_q;
            p_d       = s_sel_q;
            m_d       = 1'b0;
            if (load) begin
               s_data_d = data_in;
               s_sel_d  = unit_sel_in;
            end else begin
               s_valid_d = 1'b0;
               s_data_d  = '0;
               s_sel_d   = '0;
            end
         end else if (load) begin
            h_valid_d = 1'b1;
            h_data_d  = data_in;
            p_d       = unit_sel_in;
            m_d       = 1'b0;
         end else begin
            h_valid_d = 1'b0;
            h_data_d  = '0;
            p_d       = '0;
            m_d       = 1'b0;
         end
      end else if (HAS_SKID && load) begin
         s_valid_d = 1'b1;
         s_data_d  = data_in;
         s_sel_d   = unit_sel_in;
      end
   end

   // state registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_valid_q <= 1'b0;
         h_data_q  <= '0;
         p_q       <= '0;
         m_q       <= 1'b0;
         s_valid_q <= 1'b0;
         s_data_q  <= '0;
         s_sel_q   <= '0;
      end else begin
         h_valid_q <= h_valid_d;
         h_data_q  <= h_data_d;
         p_q       <= p_d;
         m_q       <= m_d;
         s_valid_q <= s_valid_d;
         s_data_q  <= s_data_d;
         s_sel_q   <= s_sel_d;
      end
   end

endmodule
